// File: rtl/contactor_sequencer_if.sv
// Bundles the shutdown/ack/feedback inputs and relay/status outputs of the contactor sequencer.
interface contactor_sequencer_if;
    logic       shutdown;
    logic       ack_pulse;
    logic       fb_open_a;
    logic       fb_open_b;
    logic       relay_a;
    logic       relay_b;
    logic       relay_fault;
    logic       run_ok;
    logic [2:0] state_o;
    logic [7:0] fault_count;

    modport master (
        output shutdown,
        output ack_pulse,
        output fb_open_a,
        output fb_open_b,
        input  relay_a,
        input  relay_b,
        input  relay_fault,
        input  run_ok,
        input  state_o,
        input  fault_count
    );

    modport slave (
        input  shutdown,
        input  ack_pulse,
        input  fb_open_a,
        input  fb_open_b,
        output relay_a,
        output relay_b,
        output relay_fault,
        output run_ok,
        output state_o,
        output fault_count
    );
endinterface

// File: rtl/contactor_sequencer.sv
// Staggered two-contactor energisation with mirror-contact supervision and latched relay fault.
// Optional fault event counter enabled by defining CONTACTOR_FAULT_CNT_EN.
module contactor_sequencer #(
    parameter int unsigned STAGGER_CYC    = 1000,
    parameter int unsigned FB_TIMEOUT_CYC = 240000,
    parameter int unsigned DISC_CYC       = 24000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    contactor_sequencer_if.slave bus
);

    localparam int unsigned FCNT_W = 8;
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FB_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] DISC_LAST    = CNT_W'(DISC_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_CLOSE_A = 3'd1,
        S_CLOSE_B = 3'd2,
        S_ON      = 3'd3,
        S_OPENING = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fa_sync, fb_sync;
    logic             fa, fb;
    logic             relay_a_q, relay_b_q, fault_q, run_ok_q;
    logic             relay_a_d, relay_b_d, fault_d, run_ok_d;

    // Mirror contacts are asynchronous pins; reset to "released" so OFF never sees a false weld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_sync <= 2'b11;
            fb_sync <= 2'b11;
        end else begin
            fa_sync <= {fa_sync[0], bus.fb_open_a};
            fb_sync <= {fb_sync[0], bus.fb_open_b};
        end
    end

    assign fa = fa_sync[1];
    assign fb = fb_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            relay_a_q <= 1'b0;
            relay_b_q <= 1'b0;
            fault_q   <= 1'b0;
            run_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relay_a_q <= relay_a_d;
            relay_b_q <= relay_b_d;
            fault_q   <= fault_d;
            run_ok_q  <= run_ok_d;
        end
    end

    // Next state, shared counter and next-cycle output decode; shutdown outranks expiries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_OFF: begin
                if (!bus.shutdown) begin
                    cnt_d   = '0;
                    state_d = (fa && fb) ? S_CLOSE_A : S_FAULT;
                end
            end
            S_CLOSE_A: begin
                if (bus.shutdown) begin
                    state_d = S_OPENING;
                    cnt_d   = '0;
                end else if (cnt_q == STAGGER_LAST) begin
                    state_d = S_CLOSE_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLOSE_B: begin
                if (bus.shutdown) begin
                    state_d = S_OPENING;
                    cnt_d   = '0;
                end else if (!fa && !fb) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ON: begin
                if (bus.shutdown) begin
                    state_d = S_OPENING;
                    cnt_d   = '0;
                end else if (fa || fb) begin
                    if (cnt_q == DISC_LAST) begin
                        state_d = S_FAULT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            S_OPENING: begin
                if (fa && fb) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                cnt_d = '0;
                if (bus.ack_pulse && bus.shutdown && fa && fb) begin
                    state_d = S_OFF;
                end
            end
            default: begin
                state_d = S_FAULT;
                cnt_d   = '0;
            end
        endcase

        relay_a_d = (state_d == S_CLOSE_A) || (state_d == S_CLOSE_B) || (state_d == S_ON);
        relay_b_d = (state_d == S_CLOSE_B) || (state_d == S_ON);
        fault_d   = (state_d == S_FAULT);
        run_ok_d  = (state_d == S_ON);
    end

    assign bus.relay_a     = relay_a_q;
    assign bus.relay_b     = relay_b_q;
    assign bus.relay_fault = fault_q;
    assign bus.run_ok      = run_ok_q;
    assign bus.state_o     = state_q;

`ifdef CONTACTOR_FAULT_CNT_EN
    logic [FCNT_W-1:0] fault_cnt_q;

    // Counts entries into FAULT, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= '0;
        end else if ((state_d == S_FAULT) && (state_q != S_FAULT) && (fault_cnt_q != '1)) begin
            fault_cnt_q <= fault_cnt_q + FCNT_W'(1);
        end
    end

    assign bus.fault_count = fault_cnt_q;
`else
    assign bus.fault_count = FCNT_W'(0);
`endif

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed + randomized bench for contactor_sequencer with a delayed-feedback contactor plant.
module tb_contactor_sequencer;

    localparam int unsigned STAGGER = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DISC    = 3;
    localparam int          MAX_CYC = 20000;

    localparam logic [2:0] ST_OFF = 3'd0, ST_CLOSE_A = 3'd1, ST_CLOSE_B = 3'd2,
                           ST_ON = 3'd3, ST_OPENING = 3'd4, ST_FAULT = 3'd5;

    logic clk;
    logic rst_n;
    contactor_sequencer_if bus();

    contactor_sequencer #(
        .STAGGER_CYC   (STAGGER),
        .FB_TIMEOUT_CYC(TIMEOUT),
        .DISC_CYC      (DISC),
        .CNT_W         (20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_faults = 0;

    // Plant: mirror contacts follow the coils three cycles later unless overridden.
    logic [2:0] hist_a, hist_b;
    logic       ov_a_en, ov_a_val, ov_b_en, ov_b_val;
    logic       relay_a_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        hist_a = {hist_a[1:0], bus.relay_a};
        hist_b = {hist_b[1:0], bus.relay_b};
        bus.fb_open_a = ov_a_en ? ov_a_val : !hist_a[2];
        bus.fb_open_b = ov_b_en ? ov_b_val : !hist_b[2];
        if (bus.relay_a === 1'b1) relay_a_seen = 1'b1;
        cyc++;
        if (cyc > MAX_CYC) begin
            $display("FAIL cycle_budget observed=%0d expected<=%0d", cyc, MAX_CYC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state_o !== code && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.state_o), 32'(code));
    endtask

    task automatic pulse_ack();
        bus.ack_pulse = 1'b1;
        tick();
        bus.ack_pulse = 1'b0;
    endtask

    task automatic start_to_on();
        bus.shutdown = 1'b0;
        wait_state(ST_ON, 20, "to_on");
    endtask

    // Enter FAULT from OFF through a welded A contact, leaving shutdown high afterwards.
    task automatic weld_fault_from_off();
        bus.shutdown = 1'b1;
        ov_a_en = 1'b1; ov_a_val = 1'b0;
        ov_b_en = 1'b1; ov_b_val = 1'b1;
        ticks(3);
        bus.shutdown = 1'b0;
        wait_state(ST_FAULT, 4, "weld_from_off");
        n_faults++;
        bus.shutdown = 1'b1;
    endtask

    initial begin
        int          lens[$];
        int          len;
        logic        sd, a_open, b_open, leave;
        logic [31:0] exp_fc;

        rst_n         = 1'b0;
        bus.shutdown  = 1'b1;
        bus.ack_pulse = 1'b0;
        bus.fb_open_a = 1'b1;
        bus.fb_open_b = 1'b1;
        hist_a = '0; hist_b = '0;
        ov_a_en = 1'b0; ov_a_val = 1'b0; ov_b_en = 1'b0; ov_b_val = 1'b0;
        relay_a_seen = 1'b0;

        #12;
        chk("rst_relay_a", 32'(bus.relay_a), 0);
        chk("rst_relay_b", 32'(bus.relay_b), 0);
        chk("rst_fault", 32'(bus.relay_fault), 0);
        chk("rst_run_ok", 32'(bus.run_ok), 0);
        chk("rst_state", 32'(bus.state_o), 32'(ST_OFF));
        chk("rst_fault_count", 32'(bus.fault_count), 0);

        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        chk("off_hold_shutdown", 32'(bus.state_o), 32'(ST_OFF));

        // Normal start with stagger timing
        bus.shutdown = 1'b0;
        wait_state(ST_CLOSE_A, 5, "enter_close_a");
        chk("close_a_relay_a", 32'(bus.relay_a), 1);
        chk("close_a_relay_b", 32'(bus.relay_b), 0);
        begin
            int n;
            n = 0;
            while (bus.relay_b !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("stagger_cycles", 32'(n), 32'(STAGGER));
        end
        wait_state(ST_ON, 12, "reach_on");
        chk("on_run_ok", 32'(bus.run_ok), 1);
        chk("on_no_fault", 32'(bus.relay_fault), 0);

        pulse_ack();
        tick();
        chk("ack_ignored_on", 32'(bus.state_o), 32'(ST_ON));

        // Shutdown in ON: relays drop on the next edge
        bus.shutdown = 1'b1;
        tick();
        chk("sd_relay_a", 32'(bus.relay_a), 0);
        chk("sd_relay_b", 32'(bus.relay_b), 0);
        chk("sd_opening", 32'(bus.state_o), 32'(ST_OPENING));
        chk("sd_run_ok", 32'(bus.run_ok), 0);
        wait_state(ST_OFF, 10, "opening_done");

        // Welded B while opening: timeout after exactly TIMEOUT cycles
        start_to_on();
        ov_b_en = 1'b1; ov_b_val = 1'b0;
        bus.shutdown = 1'b1;
        tick();
        chk("weld_opening", 32'(bus.state_o), 32'(ST_OPENING));
        ticks(TIMEOUT - 1);
        chk("weld_pre_timeout", 32'(bus.state_o), 32'(ST_OPENING));
        tick();
        chk("weld_timeout", 32'(bus.state_o), 32'(ST_FAULT));
        chk("weld_fault_flag", 32'(bus.relay_fault), 1);
        chk("weld_relays", 32'({bus.relay_a, bus.relay_b}), 0);
        n_faults++;
        ticks(3);
        pulse_ack();
        tick();
        chk("ack_while_welded", 32'(bus.state_o), 32'(ST_FAULT));
        ov_b_en = 1'b0;
        ticks(4);
        pulse_ack();
        chk("ack_clears", 32'(bus.state_o), 32'(ST_OFF));
        chk("ack_fault_clear", 32'(bus.relay_fault), 0);

        // Dropout pulses: fault only when discrepancy lasts DISC cycles
        lens = '{2, 5};
        for (int i = 0; i < 6; i++) lens.push_back(int'($urandom_range(1, 6)));
        foreach (lens[k]) begin
            len = lens[k];
            if (bus.state_o !== ST_ON) start_to_on();
            ov_a_en = 1'b1; ov_a_val = 1'b1;
            ticks(len);
            ov_a_en = 1'b0;
            ticks(6);
            chk($sformatf("dropout_len%0d", len), 32'(bus.state_o),
                32'((len >= int'(DISC)) ? ST_FAULT : ST_ON));
            if (len >= int'(DISC)) begin
                n_faults++;
                chk("dropout_relay_a", 32'(bus.relay_a), 0);
                bus.shutdown = 1'b1;
                ticks(6);
                pulse_ack();
                chk("dropout_recover", 32'(bus.state_o), 32'(ST_OFF));
            end
        end

        // Asynchronous reset mid-sequence
        if (bus.state_o !== ST_ON) start_to_on();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_relay_a", 32'(bus.relay_a), 0);
        chk("async_rst_relay_b", 32'(bus.relay_b), 0);
        chk("async_rst_state", 32'(bus.state_o), 32'(ST_OFF));

        // Welded A at reset release: fault without ever energising
        bus.shutdown = 1'b1;
        ov_a_en = 1'b1; ov_a_val = 1'b0;
        ticks(2);
        @(negedge clk);
        rst_n = 1'b1;
        relay_a_seen = 1'b0;
        ticks(4);
        bus.shutdown = 1'b0;
        ticks(6);
        chk("start_weld_fault", 32'(bus.state_o), 32'(ST_FAULT));
        chk("start_weld_no_relay", 32'(relay_a_seen), 0);
        n_faults++;

        // Random exit attempts: FAULT is left only with ack, shutdown and both contacts released
        for (int i = 0; i < 12; i++) begin
            if (i == 11) begin
                sd = 1'b1; a_open = 1'b1; b_open = 1'b1;
            end else begin
                sd     = 1'($urandom_range(0, 1));
                a_open = 1'($urandom_range(0, 1));
                b_open = 1'($urandom_range(0, 1));
            end
            leave = sd & a_open & b_open;
            bus.shutdown = sd;
            ov_a_en = 1'b1; ov_a_val = a_open;
            ov_b_en = 1'b1; ov_b_val = b_open;
            ticks(4);
            pulse_ack();
            chk($sformatf("ack_rand sd%0d a%0d b%0d", sd, a_open, b_open),
                32'(bus.state_o), 32'(leave ? ST_OFF : ST_FAULT));
            chk("ack_rand_flag", 32'(bus.relay_fault), 32'(!leave));
            if (leave && i != 11) weld_fault_from_off();
        end

        // Shutdown coinciding with CLOSE_B timeout wins; without it the timeout faults
        bus.shutdown = 1'b1;
        ov_a_en = 1'b1; ov_a_val = 1'b1;
        ov_b_en = 1'b1; ov_b_val = 1'b1;
        ticks(4);
        bus.shutdown = 1'b0;
        wait_state(ST_CLOSE_B, 12, "stuck_close_b");
        ticks(TIMEOUT - 1);
        chk("close_b_pre_timeout", 32'(bus.state_o), 32'(ST_CLOSE_B));
        bus.shutdown = 1'b1;
        tick();
        chk("sd_beats_timeout", 32'(bus.state_o), 32'(ST_OPENING));
        wait_state(ST_OFF, 6, "stuck_opening_done");
        bus.shutdown = 1'b0;
        wait_state(ST_CLOSE_B, 12, "stuck_close_b2");
        ticks(TIMEOUT);
        chk("close_b_timeout", 32'(bus.state_o), 32'(ST_FAULT));
        n_faults++;
        bus.shutdown = 1'b1;
        ticks(3);
        pulse_ack();
        chk("timeout_recover", 32'(bus.state_o), 32'(ST_OFF));

`ifdef CONTACTOR_FAULT_CNT_EN
        chk("fault_count_exact", 32'(bus.fault_count), 32'(n_faults));
        for (int i = 0; i < 300; i++) begin
            weld_fault_from_off();
            ov_a_val = 1'b1;
            ticks(3);
            pulse_ack();
        end
        exp_fc = (n_faults > 255) ? 32'd255 : 32'(n_faults);
`else
        exp_fc = 32'd0;
`endif
        chk("fault_count_final", 32'(bus.fault_count), exp_fc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
